fp_op_sequencer: RTL and testbench

//  Upstream issue stage for the single-precision FP arithmetic unit (adder_fp / multiplier_fp port shape).

---
 rtl/fp_pkg.sv | 17 +
 rtl/fp_sync_fifo.sv | 35 +++
 rtl/fp_op_sequencer.sv | 102 ++++++++++
 tb/tb_fp_op_sequencer.sv | 197 +++++++++++++++++++
 4 files changed

// File: rtl/fp_pkg.sv
// fp_pkg: binary32 field view, constants and sequencer state for fp_op_sequencer
package fp_pkg;
  typedef struct packed {
    logic       sign;
    logic [7:0] exp;
    logic [22:0] mant;
  } fp32_t;
  typedef enum logic {IDLE, WAIT} seq_state_t;
  localparam logic [7:0] EXP_MAX = 8'hFF;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  function automatic logic is_nan(input fp32_t x);
    return x.exp == EXP_MAX && x.mant != '0;
  endfunction
  function automatic logic is_zero(input fp32_t x);
    return {x.exp, x.mant} == '0;
  endfunction
endpackage

// File: rtl/fp_sync_fifo.sv
// fp_sync_fifo: synchronous FIFO with occupancy count and head read straight from the storage registers
module fp_sync_fifo #(
  parameter int WIDTH = 64,
  parameter int DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       din,
  output logic [WIDTH-1:0]       dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wp, rp;
  always_ff @(posedge clk)
    if (push) mem[wp] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wp <= '0;
      rp <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (pop) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  end
  assign dout = mem[rp];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
endmodule

// File: rtl/fp_op_sequencer.sv
// fp_op_sequencer: buffers binary32 operand pairs and issues them one at a time to an FP unit, returning results in order.
// Define FP_SPECIAL_BYPASS_EN to resolve NaN/zero operand pairs locally without occupying the unit.
module fp_op_sequencer
  import fp_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int TIMEOUT = 64
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [31:0]            in_A,
  input  logic [31:0]            in_B,
  output logic [31:0]            A,
  output logic [31:0]            B,
  output logic                   start,
  input  logic                   ready,
  input  logic                   busy,
  input  logic [31:0]            Y,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [31:0]            out_Y,
  output logic [$clog2(DEPTH):0] count,
  output logic                   timeout_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  seq_state_t state, state_nx;
  logic [63:0] head;
  logic full, empty, pop, issue, bypass, tmo, slot_free;
  logic [31:0] a_q, b_q, byp_y;
  logic [TW-1:0] wait_cnt;
  fp_sync_fifo #(.WIDTH(64), .DEPTH(DEPTH)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(in_valid && !full),
    .pop(pop),
    .din({in_A, in_B}),
    .dout(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
  assign in_ready = !full;
  assign slot_free = !out_valid || out_ready;
`ifdef FP_SPECIAL_BYPASS_EN
  fp32_t ha, hb;
  assign ha = head[63:32];
  assign hb = head[31:0];
  assign bypass = state == IDLE && !empty && slot_free &&
                  (is_nan(ha) || is_nan(hb) || is_zero(ha) || is_zero(hb));
  assign byp_y = (is_nan(ha) || is_nan(hb)) ? QNAN :
                 (is_zero(ha) && is_zero(hb)) ? {ha.sign & hb.sign, 31'b0} :
                 is_zero(ha) ? hb : ha;
`else
  assign bypass = 1'b0;
  assign byp_y = '0;
`endif
  always_ff @(posedge clk)
    state <= reset ? IDLE : state_nx;
  always_comb begin
    state_nx = issue ? WAIT : (state == WAIT && (ready || tmo)) ? IDLE : state;
  end
  // A/B come straight from the FIFO head during the issue cycle, then from the hold registers
  always_comb begin
    issue = state == IDLE && !empty && !busy && slot_free && !bypass;
    start = issue;
    pop = issue || bypass;
    tmo = state == WAIT && !ready && wait_cnt == TW'(TIMEOUT - 1);
    A = issue ? head[63:32] : a_q;
    B = issue ? head[31:0] : b_q;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      a_q <= '0;
      b_q <= '0;
      wait_cnt <= '0;
      out_Y <= '0;
      out_valid <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      if (issue) begin
        a_q <= head[63:32];
        b_q <= head[31:0];
      end
      wait_cnt <= issue ? '0 : state == WAIT ? wait_cnt + TW'(1) : wait_cnt;
      if (state == WAIT && ready) begin
        out_Y <= Y;
        out_valid <= 1'b1;
      end else if (tmo) begin
        out_Y <= QNAN;
        out_valid <= 1'b1;
        timeout_err <= 1'b1;
      end else if (bypass) begin
        out_Y <= byp_y;
        out_valid <= 1'b1;
      end else if (out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_fp_op_sequencer.sv
// tb_fp_op_sequencer: directed scoreboard bench for fp_op_sequencer with a latency-programmable unit model (Y = A ^ B)
module tb_fp_op_sequencer;
  logic clk = 1'b0;
  logic reset, in_valid, in_ready, start, busy, out_valid, out_ready, timeout_err;
  logic ready = 1'b0;
  logic [31:0] in_A, in_B, A, B, out_Y;
  logic [31:0] Y = '0;
  logic [2:0] count;
  int vectors = 0, miscompares = 0, nstarts = 0, nvalid = 0;
  int lat = 3, rem = 0;
  logic hang = 1'b0;
  logic [31:0] yv = '0;
  logic [31:0] sb[$];

  fp_op_sequencer #(.DEPTH(4), .TIMEOUT(64)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_A(in_A), .in_B(in_B), .A(A), .B(B), .start(start), .ready(ready),
    .busy(busy), .Y(Y), .out_valid(out_valid), .out_ready(out_ready),
    .out_Y(out_Y), .count(count), .timeout_err(timeout_err)
  );

  always #5 clk = ~clk;

  // unit model: ready pulses lat cycles after the start cycle unless hung; ignores reset
  always @(posedge clk) begin
    ready <= 1'b0;
    if (start) begin
      rem <= lat - 1;
      yv <= A ^ B;
    end else if (rem > 0) begin
      rem <= rem - 1;
      if (rem == 1 && !hang) begin
        ready <= 1'b1;
        Y <= yv;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (start) nstarts++;
    if (out_valid) nvalid++;
    if (!reset && out_valid && out_ready) begin
      if (sb.size() == 0) chk("unexpected_out", out_Y, 32'hxxxxxxxx);
      else chk("out_Y", out_Y, sb.pop_front());
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] a, input logic [31:0] b, input logic [31:0] e);
    logic acc;
    acc = 1'b0;
    in_valid = 1'b1;
    in_A = a;
    in_B = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = in_ready;
      tick();
    end
    in_valid = 1'b0;
    if (acc) sb.push_back(e);
    else chk("push_accept", 32'(acc), 32'd1);
  endtask

  task automatic drain();
    for (int i = 0; i < 400 && (sb.size() != 0 || out_valid); i++) tick();
    chk("drain_empty", 32'(sb.size()), 32'd0);
  endtask

  initial begin
    int n, s0, v0;
    reset = 1'b1; in_valid = 1'b0; in_A = '0; in_B = '0; out_ready = 1'b1; busy = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_count", 32'(count), 32'd0);
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_Y", out_Y, 32'd0);
    chk("rst_start", 32'(start), 32'd0);
    chk("rst_A", A, 32'd0);
    chk("rst_B", B, 32'd0);
    chk("rst_timeout_err", 32'(timeout_err), 32'd0);
    tick();
    reset = 1'b0;
    // single op, L=3: pushed in cycle 0
    in_valid = 1'b1; in_A = 32'h3F800000; in_B = 32'h40000000;
    sb.push_back(32'h7F800000);
    for (int k = 0; k <= 5; k++) begin
      @(negedge clk);
      chk("t1_start", 32'(start), 32'(k == 1));
      chk("t1_out_valid", 32'(out_valid), 32'(k == 5));
      if (k == 1) begin
        chk("t1_A", A, 32'h3F800000);
        chk("t1_B", B, 32'h40000000);
        chk("t1_count", 32'(count), 32'd1);
      end
      tick();
      in_valid = 1'b0;
    end
    drain();
    // fill with consumer stalled
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++)
      push(32'h3F800000 + i, 32'h40000000 + (i << 4), (32'h3F800000 + i) ^ (32'h40000000 + (i << 4)));
    repeat (12) tick();
    @(negedge clk);
    chk("t2_count_full", 32'(count), 32'd4);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    chk("t2_out_valid", 32'(out_valid), 32'd1);
    chk("t2_held_Y", out_Y, 32'h7F800000);
    tick();
    out_ready = 1'b1;
    drain();
    // watchdog: unit never answers
    hang = 1'b1;
    push(32'h40000000, 32'h40400000, 32'h7FC00000);
    n = 0;
    @(negedge clk);
    while (!start && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk("t3_start_seen", 32'(start), 32'd1);
    n = 0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      n++;
      if (out_valid) break;
    end
    chk("t3_cycles_to_qnan", 32'(n), 32'd65);
    chk("t3_timeout_err", 32'(timeout_err), 32'd1);
    tick();
    hang = 1'b0;
    push(32'h12345678, 32'h0F0F0F0F, 32'h1D3B5977);
    drain();
    chk("t3_err_sticky", 32'(timeout_err), 32'd1);
    // busy gating
    busy = 1'b1;
    push(32'h41200000, 32'h41A00000, 32'h41200000 ^ 32'h41A00000);
    s0 = nstarts;
    repeat (10) tick();
    chk("t4_no_start", 32'(nstarts - s0), 32'd0);
    chk("t4_count", 32'(count), 32'd1);
    busy = 1'b0;
    @(negedge clk);
    chk("t4_start_after_busy", 32'(start), 32'd1);
    tick();
    drain();
    // reset while waiting, two pairs queued
    lat = 10;
    push(32'h3F800000, 32'h3F800001, 32'h0);
    push(32'h3F800002, 32'h3F800003, 32'h0);
    push(32'h3F800004, 32'h3F800005, 32'h0);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("t5_count", 32'(count), 32'd0);
    chk("t5_out_valid", 32'(out_valid), 32'd0);
    chk("t5_in_ready", 32'(in_ready), 32'd1);
    tick();
    s0 = nstarts;
    v0 = nvalid;
    repeat (15) tick();
    chk("t5_late_ready_ignored", 32'(nvalid - v0), 32'd0);
    chk("t5_no_start", 32'(nstarts - s0), 32'd0);
    lat = 3;
    // special operand pairs
    s0 = nstarts;
`ifdef FP_SPECIAL_BYPASS_EN
    push(32'h00000000, 32'h40400000, 32'h40400000);
    push(32'h7FC00001, 32'h3F800000, 32'h7FC00000);
    drain();
    chk("t6_no_start", 32'(nstarts - s0), 32'd0);
`else
    push(32'h00000000, 32'h40400000, 32'h40400000);
    push(32'h7FC00001, 32'h3F800000, 32'h40400001);
    drain();
    chk("t6_issued", 32'(nstarts - s0), 32'd2);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
